// File: rtl/cache_pkg.sv
// Shared definitions for the data-cache refill path.
// Holds the refill FSM state type, line geometry constants and the address
// field boundaries used by both the cache and its refill controller.
package cache_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StFill
  } refill_state_e;

  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned WORD_OFF_W     = 2;  // word index within a line
  localparam int unsigned LINE_OFF_W     = 4;  // byte offset within a line

  // Address field slices shared with the cache lookup.
  localparam int unsigned TAG_MSB  = 31;
  localparam int unsigned TAG_LSB  = 6;
  localparam int unsigned SET_MSB  = 5;
  localparam int unsigned SET_LSB  = 4;
  localparam int unsigned WOFF_MSB = 3;
  localparam int unsigned WOFF_LSB = 2;

endpackage

// File: rtl/line_buffer.sv
// Four-entry capture register holding one cache line during a refill.
// Ports:
//   clk_i, rst_i       clock and asynchronous active-high clear
//   we_i, idx_i        write enable and word index of the incoming word
//   wdata_i            word to capture
//   d0_o..d3_o         stored words at offsets 0..3
module line_buffer
  import cache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [WORD_OFF_W-1:0] idx_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] d0_o,
  output logic [DATA_WIDTH-1:0] d1_o,
  output logic [DATA_WIDTH-1:0] d2_o,
  output logic [DATA_WIDTH-1:0] d3_o
);

  logic [DATA_WIDTH-1:0] words_q [WORDS_PER_LINE];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < WORDS_PER_LINE; i++) begin
        words_q[i] <= '0;
      end
    end else if (we_i) begin
      words_q[idx_i] <= wdata_i;
    end
  end

  assign d0_o = words_q[0];
  assign d1_o = words_q[1];
  assign d2_o = words_q[2];
  assign d3_o = words_q[3];

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss handler for the 4-set, 4-word-line direct-mapped data cache.
// On a miss it stalls the pipeline, reads the aligned line from memory one
// word per handshake (order 0..3), then pulses fill_o for one cycle so the
// cache can write d0..d3 under fill_tag_addr_o.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   access_i, miss_i, addr_i  MEM-stage load lookup result and byte address
//   stall_o, busy_o           pipeline freeze / controller not idle
//   mem_req_o, mem_addr_o     level read request and word address
//   mem_rvalid_i, mem_rdata_i read completion and data
//   fill_o, fill_tag_addr_o   one-cycle cache write strobe and line base
//   d0_o..d3_o                captured line words
module cache_refill_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  access_i,
  input  logic                  miss_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  stall_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  fill_o,
  output logic [ADDR_WIDTH-1:0] fill_tag_addr_o,
  output logic [DATA_WIDTH-1:0] d0_o,
  output logic [DATA_WIDTH-1:0] d1_o,
  output logic [DATA_WIDTH-1:0] d2_o,
  output logic [DATA_WIDTH-1:0] d3_o,
  output logic                  busy_o
);

  import cache_pkg::*;

  localparam logic [WORD_OFF_W-1:0] LastWord = WORD_OFF_W'(WORDS_PER_LINE - 1);

  refill_state_e         state_q, state_d;
  logic [WORD_OFF_W-1:0] k_q, k_d;
  logic [ADDR_WIDTH-1:0] line_base_q, line_base_d;
  logic                  buf_we;

  // Byte offset within the line never affects which line is fetched.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^addr_i[LINE_OFF_W-1:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      k_q         <= '0;
      line_base_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      line_base_q <= line_base_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    line_base_d = line_base_q;
    unique case (state_q)
      StIdle: begin
        if (access_i && miss_i) begin
          line_base_d = {addr_i[ADDR_WIDTH-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
          k_d         = '0;
          state_d     = StFetch;
        end
      end
      StFetch: begin
        if (mem_rvalid_i) begin
          if (k_q == LastWord) begin
            state_d = StFill;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      StFill:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy_o     = (state_q != StIdle);
    stall_o    = ((state_q == StIdle) && access_i && miss_i) || (state_q != StIdle);
    mem_req_o  = (state_q == StFetch);
    fill_o     = (state_q == StFill);
    buf_we     = (state_q == StFetch) && mem_rvalid_i;
    mem_addr_o = '0;
    if (state_q == StFetch) begin
      // Base has a zero line offset, so the word address is a pure splice.
      mem_addr_o = {line_base_q[ADDR_WIDTH-1:LINE_OFF_W], k_q, 2'b00};
    end
  end

  assign fill_tag_addr_o = line_base_q;

  line_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_line_buffer (
    .clk_i  (clk),
    .rst_i  (rst),
    .we_i   (buf_we),
    .idx_i  (k_q),
    .wdata_i(mem_rdata_i),
    .d0_o   (d0_o),
    .d1_o   (d1_o),
    .d2_o   (d2_o),
    .d3_o   (d3_o)
  );

endmodule
